// File: rtl/noc_wormhole_arbiter.sv
// noc_wormhole_arbiter: YX-routing switch allocator for a 5-port mesh router, with wormhole locking and credit gating.
// Define ARB_HEADER_LEN_EN to take each packet's length from its header len field instead of PKT_LEN.
//
// state      | meaning
// IN_IDLE    | input waiting for a head flit
// IN_REQ     | route latched in next_hop, requesting that output
// IN_ACTIVE  | input owns its output until the last flit leaves
// OUT_FREE   | output grants one requester round-robin from rr_ptr
// OUT_LOCKED | output held by owner for the whole packet
module noc_wormhole_arbiter #(
   parameter int COORD_W      = 4,
   parameter int LEN_W        = 4,
   parameter int PKT_LEN      = 4,
   parameter int CREDIT_DEPTH = 4,
   parameter int SEL_W        = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2*COORD_W-1:0]             yx_pos_i,
   input  logic [4:0]                       arb_empty_i,
   input  logic [5*(LEN_W+2*COORD_W)-1:0]   arb_header_i,
   input  logic [4:0]                       arb_credit_i,
   output logic [4:0]                       arb_read_o,
   output logic [4:0]                       arb_credit_o,
   output logic [4:0]                       arb_valid_o,
   output logic [5*SEL_W-1:0]               arb_mux_sel_o,
   output logic [5*SEL_W-1:0]               arb_demux_sel_o,
   output logic                             arb_err_o
);
   localparam int NP    = 5;
   localparam int HDR_W = LEN_W + 2*COORD_W;
   localparam int CRD_W = $clog2(CREDIT_DEPTH + 1);

   localparam logic [SEL_W-1:0] PORT_N = SEL_W'(0);
   localparam logic [SEL_W-1:0] PORT_S = SEL_W'(1);
   localparam logic [SEL_W-1:0] PORT_W = SEL_W'(2);
   localparam logic [SEL_W-1:0] PORT_E = SEL_W'(3);
   localparam logic [SEL_W-1:0] PORT_L = SEL_W'(4);

   localparam logic [1:0] IN_IDLE   = 2'd0;
   localparam logic [1:0] IN_REQ    = 2'd1;
   localparam logic [1:0] IN_ACTIVE = 2'd2;
   localparam logic [0:0] OUT_FREE   = 1'b0;
   localparam logic [0:0] OUT_LOCKED = 1'b1;

   logic [1:0]        in_state  [NP];
   logic [SEL_W-1:0]  next_hop  [NP];
   logic [0:0]        out_state [NP];
   logic [SEL_W-1:0]  owner     [NP];
   logic [SEL_W-1:0]  rr_ptr    [NP];
   logic [LEN_W-1:0]  flit_cnt  [NP];
   logic [CRD_W-1:0]  credit    [NP];
   logic              err_q;

   logic [SEL_W-1:0]  route     [NP];
   logic [SEL_W-1:0]  grant_idx [NP];
   logic [LEN_W-1:0]  last_idx  [NP];
   logic [NP-1:0]     route_bad;
   logic [NP-1:0]     in_latch;
   logic [NP-1:0]     grant_vld;
   logic [NP-1:0]     xfer;
   logic [NP-1:0]     last_flit;
   logic [NP-1:0]     cred_ovf;
   logic [NP-1:0]     in_granted;
   logic [NP-1:0]     in_done;

   wire [COORD_W-1:0] my_y = yx_pos_i[2*COORD_W-1:COORD_W];
   wire [COORD_W-1:0] my_x = yx_pos_i[COORD_W-1:0];

`ifdef ARB_HEADER_LEN_EN
   logic [LEN_W-1:0]  pkt_len   [NP];
`else
   logic              unused_hdr_len;
   always_comb begin
      unused_hdr_len = 1'b0;
      for (int p = 0; p < NP; p++)
         unused_hdr_len = unused_hdr_len ^ (^arb_header_i[p*HDR_W + 2*COORD_W +: LEN_W]);
   end
`endif

   // YX route on the head flit; a U-turn back out the arriving port is diverted to L
   always_comb begin
      route_bad = '0;
      in_latch  = '0;
      for (int p = 0; p < NP; p++) begin
         if (arb_header_i[p*HDR_W + COORD_W +: COORD_W] < my_y)
            route[p] = PORT_N;
         else if (arb_header_i[p*HDR_W + COORD_W +: COORD_W] > my_y)
            route[p] = PORT_S;
         else if (arb_header_i[p*HDR_W +: COORD_W] < my_x)
            route[p] = PORT_W;
         else if (arb_header_i[p*HDR_W +: COORD_W] > my_x)
            route[p] = PORT_E;
         else
            route[p] = PORT_L;
         route_bad[p] = (p != NP-1) && (route[p] == SEL_W'(p));
         if (route_bad[p])
            route[p] = PORT_L;
         in_latch[p] = (in_state[p] == IN_IDLE) && !arb_empty_i[p];
      end
   end

   always_comb begin
      grant_vld = '0;
      for (int o = 0; o < NP; o++) begin
         grant_idx[o] = '0;
         if (out_state[o] == OUT_FREE) begin
            for (int k = 0; k < NP; k++) begin
               if (!grant_vld[o] &&
                   in_state[(int'(rr_ptr[o]) + k) % NP] == IN_REQ &&
                   next_hop[(int'(rr_ptr[o]) + k) % NP] == SEL_W'(o)) begin
                  grant_vld[o] = 1'b1;
                  grant_idx[o] = SEL_W'((int'(rr_ptr[o]) + k) % NP);
               end
            end
         end
      end
   end

   always_comb begin
      xfer          = '0;
      last_flit     = '0;
      cred_ovf      = '0;
      in_granted    = '0;
      in_done       = '0;
      arb_read_o    = '0;
      arb_valid_o   = '0;
      arb_mux_sel_o = '0;
      for (int o = 0; o < NP; o++) begin
`ifdef ARB_HEADER_LEN_EN
         last_idx[o] = pkt_len[owner[o]] - LEN_W'(1);
`else
         last_idx[o] = LEN_W'(PKT_LEN - 1);
`endif
         if (out_state[o] == OUT_LOCKED) begin
            arb_mux_sel_o[o*SEL_W +: SEL_W] = owner[o];
            xfer[o]      = !arb_empty_i[owner[o]] && (credit[o] != '0);
            last_flit[o] = xfer[o] && (flit_cnt[o] == last_idx[o]);
            arb_read_o[owner[o]] = arb_read_o[owner[o]] | xfer[o];
            in_done[owner[o]]    = in_done[owner[o]] | last_flit[o];
         end
         arb_valid_o[o] = xfer[o];
         cred_ovf[o]    = arb_credit_i[o] && !xfer[o] && (credit[o] == CRD_W'(CREDIT_DEPTH));
         if (grant_vld[o])
            in_granted[grant_idx[o]] = 1'b1;
      end
   end

   always_comb begin
      arb_demux_sel_o = '0;
      for (int p = 0; p < NP; p++)
         arb_demux_sel_o[p*SEL_W +: SEL_W] = next_hop[p];
   end

   assign arb_credit_o = arb_read_o;
   assign arb_err_o    = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            in_state[p] <= IN_IDLE;
            next_hop[p] <= '0;
`ifdef ARB_HEADER_LEN_EN
            pkt_len[p]  <= LEN_W'(1);
`endif
         end
      end else begin
         for (int p = 0; p < NP; p++) begin
            case (in_state[p])
               IN_IDLE: if (in_latch[p]) begin
                  next_hop[p] <= route[p];
                  in_state[p] <= IN_REQ;
`ifdef ARB_HEADER_LEN_EN
                  // a zero length still carries the header flit
                  pkt_len[p]  <= (arb_header_i[p*HDR_W + 2*COORD_W +: LEN_W] == '0) ? LEN_W'(1)
                                 : arb_header_i[p*HDR_W + 2*COORD_W +: LEN_W];
`endif
               end
               IN_REQ:    if (in_granted[p]) in_state[p] <= IN_ACTIVE;
               IN_ACTIVE: if (in_done[p])    in_state[p] <= IN_IDLE;
               default:   in_state[p] <= IN_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int o = 0; o < NP; o++) begin
            out_state[o] <= OUT_FREE;
            owner[o]     <= '0;
            rr_ptr[o]    <= '0;
            flit_cnt[o]  <= '0;
            credit[o]    <= CRD_W'(CREDIT_DEPTH);
         end
         err_q <= 1'b0;
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (out_state[o] == OUT_FREE) begin
               if (grant_vld[o]) begin
                  out_state[o] <= OUT_LOCKED;
                  owner[o]     <= grant_idx[o];
                  flit_cnt[o]  <= '0;
               end
            end else if (last_flit[o]) begin
               out_state[o] <= OUT_FREE;
               owner[o]     <= '0;
               flit_cnt[o]  <= '0;
               rr_ptr[o]    <= (owner[o] == SEL_W'(NP-1)) ? '0 : owner[o] + SEL_W'(1);
            end else if (xfer[o]) begin
               flit_cnt[o]  <= flit_cnt[o] + LEN_W'(1);
            end
            case ({xfer[o], arb_credit_i[o]})
               2'b10:   credit[o] <= credit[o] - CRD_W'(1);
               2'b01:   if (!cred_ovf[o]) credit[o] <= credit[o] + CRD_W'(1);
               default: credit[o] <= credit[o];
            endcase
         end
         err_q <= err_q | (|cred_ovf) | (|(route_bad & in_latch));
      end
   end
endmodule

// File: tb/tb_noc_wormhole_arbiter.sv
// tb_noc_wormhole_arbiter: directed and randomized checks of the switch allocator
// against a packet-level reference model (owners, remaining flits, credit pools).
module tb_noc_wormhole_arbiter;
   localparam int COORD_W = 4, LEN_W = 4, PKT_LEN = 4, CREDIT_DEPTH = 4, SEL_W = 3;
   localparam int HDR_W = LEN_W + 2*COORD_W;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  yx_pos_i;
   logic [4:0]  arb_empty_i;
   logic [59:0] arb_header_i;
   logic [4:0]  arb_credit_i;
   logic [4:0]  arb_read_o, arb_credit_o, arb_valid_o;
   logic [14:0] arb_mux_sel_o, arb_demux_sel_o;
   logic        arb_err_o;

   noc_wormhole_arbiter #(.COORD_W(COORD_W), .LEN_W(LEN_W), .PKT_LEN(PKT_LEN),
                          .CREDIT_DEPTH(CREDIT_DEPTH), .SEL_W(SEL_W)) dut (
      .clk(clk), .reset(reset), .yx_pos_i(yx_pos_i), .arb_empty_i(arb_empty_i),
      .arb_header_i(arb_header_i), .arb_credit_i(arb_credit_i), .arb_read_o(arb_read_o),
      .arb_credit_o(arb_credit_o), .arb_valid_o(arb_valid_o), .arb_mux_sel_o(arb_mux_sel_o),
      .arb_demux_sel_o(arb_demux_sel_o), .arb_err_o(arb_err_o));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // reference model: who holds each output, flits still owed, credits left
   int m_want  [5];   // 0 no packet, 1 waiting for grant, 2 moving flits
   int m_hop   [5];
   int m_plen  [5];
   int m_owner [5];   // -1 when the output is free
   int m_left  [5];
   int m_rr    [5];
   int m_cred  [5];
   bit m_err;

   logic [4:0]  got_read, got_valid;
   logic [14:0] got_mux, got_demux;
   logic        got_err;

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_want[i] = 0; m_hop[i] = 0; m_plen[i] = PKT_LEN;
         m_owner[i] = -1; m_left[i] = 0; m_rr[i] = 0; m_cred[i] = CREDIT_DEPTH;
      end
      m_err = 1'b0;
   endtask

   task automatic run_cycle();
      logic [4:0]  e_read, e_valid;
      logic [14:0] e_mux, e_demux;
      int gnt [5];
      bit xf [5];
      bit lst [5];
      int my_y, my_x, dy, dx, ln, r, idx, w;
      @(negedge clk);
      my_y = int'(yx_pos_i[7:4]);
      my_x = int'(yx_pos_i[3:0]);
      e_read = '0; e_valid = '0; e_mux = '0; e_demux = '0;
      for (int o = 0; o < 5; o++) begin
         gnt[o] = -1; xf[o] = 0; lst[o] = 0;
         if (m_owner[o] >= 0) begin
            w = m_owner[o];
            xf[o]  = !arb_empty_i[w] && (m_cred[o] > 0);
            lst[o] = xf[o] && (m_left[o] == 1);
            e_read[w]  = e_read[w] | xf[o];
            e_valid[o] = xf[o];
            e_mux[o*3 +: 3] = 3'(w);
         end else begin
            for (int k = 0; k < 5; k++) begin
               idx = (m_rr[o] + k) % 5;
               if (gnt[o] < 0 && m_want[idx] == 1 && m_hop[idx] == o) gnt[o] = idx;
            end
         end
      end
      for (int i = 0; i < 5; i++) e_demux[i*3 +: 3] = 3'(m_hop[i]);
      got_read = arb_read_o; got_valid = arb_valid_o; got_mux = arb_mux_sel_o;
      got_demux = arb_demux_sel_o; got_err = arb_err_o;
      check_val("read", 32'(arb_read_o), 32'(e_read));
      check_val("credit_o", 32'(arb_credit_o), 32'(e_read));
      check_val("valid", 32'(arb_valid_o), 32'(e_valid));
      check_val("mux_sel", 32'(arb_mux_sel_o), 32'(e_mux));
      check_val("demux_sel", 32'(arb_demux_sel_o), 32'(e_demux));
      check_val("err", 32'(arb_err_o), 32'(m_err));
      for (int i = 0; i < 5; i++) begin
         if (m_want[i] == 0) begin
            if (!arb_empty_i[i]) begin
               dx = int'(arb_header_i[i*HDR_W +: 4]);
               dy = int'(arb_header_i[i*HDR_W + 4 +: 4]);
               ln = int'(arb_header_i[i*HDR_W + 8 +: 4]);
               if (dy < my_y) r = 0;
               else if (dy > my_y) r = 1;
               else if (dx < my_x) r = 2;
               else if (dx > my_x) r = 3;
               else r = 4;
               if (i != 4 && r == i) begin m_err = 1'b1; r = 4; end
               m_hop[i] = r;
`ifdef ARB_HEADER_LEN_EN
               m_plen[i] = (ln == 0) ? 1 : ln;
`else
               m_plen[i] = PKT_LEN;
`endif
               m_want[i] = 1;
            end
         end else if (m_want[i] == 1) begin
            for (int o = 0; o < 5; o++) if (gnt[o] == i) m_want[i] = 2;
         end else begin
            for (int o = 0; o < 5; o++) if (lst[o] && m_owner[o] == i) m_want[i] = 0;
         end
      end
      for (int o = 0; o < 5; o++) begin
         if (gnt[o] >= 0) begin
            m_owner[o] = gnt[o];
            m_left[o]  = m_plen[gnt[o]];
         end else if (xf[o]) begin
            m_left[o]--;
            if (lst[o]) begin
               m_rr[o] = (m_owner[o] + 1) % 5;
               m_owner[o] = -1;
            end
         end
         if (xf[o] && !arb_credit_i[o]) m_cred[o]--;
         else if (!xf[o] && arb_credit_i[o]) begin
            if (m_cred[o] == CREDIT_DEPTH) m_err = 1'b1;
            else m_cred[o]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] pos);
      reset = 1'b1;
      yx_pos_i = pos;
      arb_empty_i = 5'h1f;
      arb_header_i = '0;
      arb_credit_i = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b0;
      yx_pos_i = 8'h22; arb_empty_i = 5'h1f; arb_header_i = '0; arb_credit_i = '0;
      #2;
      do_reset(8'h22);

      // single route L -> E: transfers in cycles 2..5
      arb_empty_i = 5'b01111;
      arb_header_i[4*HDR_W +: HDR_W] = {4'd4, 4'd2, 4'd3};
      for (int c = 0; c < 8; c++) begin
         run_cycle();
         check_val("sr_read_l", 32'(got_read[4]), 32'(c >= 2 && c <= 5));
         check_val("sr_valid_e", 32'(got_valid[3]), 32'(c >= 2 && c <= 5));
         if (c >= 2 && c <= 5) check_val("sr_mux_e", 32'(got_mux[9 +: 3]), 32'd4);
      end
      check_val("sr_err", 32'(got_err), 32'd0);

      // U-turn from N is diverted to L and flags an error
      do_reset(8'h22);
      arb_empty_i = 5'b11110;
      arb_header_i[0 +: HDR_W] = {4'd4, 4'd1, 4'd2};
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         if (c == 2) check_val("uturn_valid_l", 32'(got_valid[4]), 32'd1);
      end
      check_val("uturn_err", 32'(got_err), 32'd1);
      check_val("uturn_demux", 32'(got_demux[2:0]), 32'd4);

      // credit return at full credit
      do_reset(8'h22);
      arb_credit_i = 5'b00010;
      run_cycle();
      arb_credit_i = '0;
      run_cycle();
      check_val("ovf_err", 32'(got_err), 32'd1);

      // randomized traffic with periodic asynchronous resets mid-packet
      for (int blk = 0; blk < 6; blk++) begin
         do_reset({4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))});
         for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 5; i++) begin
               arb_empty_i[i]  = ($urandom_range(0, 3) == 0);
               arb_credit_i[i] = ($urandom_range(0, 4) == 0);
               arb_header_i[i*HDR_W +: HDR_W] = {4'($urandom_range(0, 5)),
                                                 4'($urandom_range(0, 4)),
                                                 4'($urandom_range(0, 4))};
            end
            run_cycle();
         end
         #2;
         reset = 1'b1;
         #1;
         check_val("rst_read", 32'(arb_read_o), 32'd0);
         check_val("rst_valid", 32'(arb_valid_o), 32'd0);
         check_val("rst_credit_o", 32'(arb_credit_o), 32'd0);
         check_val("rst_mux", 32'(arb_mux_sel_o), 32'd0);
         check_val("rst_demux", 32'(arb_demux_sel_o), 32'd0);
         check_val("rst_err", 32'(arb_err_o), 32'd0);
         @(posedge clk);
         #1;
         reset = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_wormhole_arbiter.md
Name: noc_wormhole_arbiter

Overview:
- Parametrised switch allocator for one 2D-mesh router with five ports, indexed 0=N, 1=S, 2=W, 3=E, 4=L.
- Performs YX route computation on each input's head flit and latches the result in a per-input next-hop register.
- Allocates each output by round-robin among requesting inputs, then holds the output wormhole-locked for a whole packet.
- Gates every flit transfer on a per-output downstream credit counter.
- Drives input-buffer pops, crossbar mux/demux selects and upstream credit returns.

Parameters:
- COORD_W, 4: width of each of the Y and X coordinates.
- LEN_W, 4: width of the header length field.
- PKT_LEN, 4: flits per packet including the header; legal range 1..2^LEN_W-1.
- CREDIT_DEPTH, 4: downstream buffer depth; also the credit counter reset value.
- SEL_W, 3: width of the port select encodings.

Ports:
- clk  in  1  router clock.
- reset  in  1  asynchronous, active-high reset.
- yx_pos_i  in  2*COORD_W  this router's position {y,x}; static.
- arb_empty_i  in  5  per-input buffer empty flag.
- arb_header_i  in  5*(LEN_W+2*COORD_W)  per-input head flit fields {len,y,x}; input p occupies slice p.
- arb_credit_i  in  5  per-output one-cycle credit return from downstream.
- arb_read_o  out  5  per-input buffer pop.
- arb_credit_o  out  5  per-input credit to upstream; equals arb_read_o.
- arb_valid_o  out  5  per-output flit transfer strobe.
- arb_mux_sel_o  out  5*SEL_W  per-output owning input index.
- arb_demux_sel_o  out  5*SEL_W  per-input registered next-hop output index.
- arb_err_o  out  1  sticky protocol error.

Behaviour:
- Route rule (YX): if dest_y < my_y → N; if dest_y > my_y → S; otherwise if dest_x < my_x → W; if dest_x > my_x → E; otherwise → L.
- Illegal route: a route equal to the arriving port, for any input other than L, sets arb_err_o and the packet is routed to L.
- Input FSM states:
  - IDLE: on arb_empty_i=0, latch the route into the next-hop register and go to REQ.
  - REQ: assert a request to the latched output.
  - ACTIVE: hold until the owning output's last flit is transferred, then return to IDLE.
  - The next head flit can be latched the cycle after the return to IDLE.
- Output FSM states:
  - FREE: each cycle grant one requester, picked by round-robin starting at rr_ptr. The grant is registered, so the state becomes LOCKED(owner) the next cycle.
  - LOCKED: hold until the last flit is transferred.
- Round-robin pointer: rr_ptr resets to 0 and is set to owner+1 mod 5 when the output releases.
- Transfer condition: in LOCKED, a transfer occurs iff arb_empty_i[owner]=0 and credit>0. A transfer asserts arb_read_o[owner], arb_credit_o[owner] and arb_valid_o[out], all combinational in the same cycle.
- Latency: head flit visible in cycle 0 → REQ in cycle 1 → grant registered → first read in cycle 2 at the earliest.
- Credits:
  - A transfer decrements the counter; arb_credit_i increments it.
  - Both in the same cycle leave the count unchanged.
  - Increment at CREDIT_DEPTH saturates and sets arb_err_o.
  - At credit 0, no transfer occurs and the flit counter holds.
- Flit counter:
  - Per output, 0..PKT_LEN-1, incremented on each transfer.
  - The transfer at PKT_LEN-1 releases the output and clears the counter.
  - The new request can win arbitration in the following cycle; minimum one-cycle bubble.
- Empty input: a locked owner going empty mid-packet stalls the output; the lock is kept.
- Multiple inputs may target different outputs concurrently. An input owns at most one output.
- Select outputs:
  - arb_mux_sel_o reads 0 when the output is FREE.
  - arb_demux_sel_o holds its value until the next latch.
- Reset values (asynchronous, any time, including mid-packet):
  - All FSMs go to IDLE/FREE, counters to 0, credits to CREDIT_DEPTH, rr_ptr to 0.
  - All outputs are 0 and arb_err_o is cleared.
  - Partial packets are discarded from arbiter state.

Optional Feature:
- Macro: ARB_HEADER_LEN_EN.
- Defined:
  - Packet length is taken from the header len field, latched with the route.
  - len=0 is treated as 1.
  - The flit counter compares against the latched length.
- Undefined: the len field is ignored and PKT_LEN is used for every packet.

Test Plan:
- Single route: reset, yx_pos_i={2,2}, input L header {y=2,x=3}, input never empty, credits full → arb_read_o[4] and arb_valid_o[3] high cycles 2–5, arb_mux_sel_o[E]=4, release in cycle 5, err=0.
- Contention: inputs N, W and L all target S in the same cycle → grants in order N, W, L; each holds 4 consecutive transfers; one idle cycle between packets; rr_ptr after L is N.
- Credit stall: CREDIT_DEPTH=4 with no arb_credit_i → 4 transfers then stall. Then pulse arb_credit_i[S] once → exactly one more transfer. Credit return and transfer in the same cycle → count unchanged.
- Stall and reset:
  - Owner goes empty after flit 2 → output stays LOCKED with no valid; resuming completes flits 3–4.
  - Reset asserted mid-packet → all outputs 0 asynchronously, credits reinitialised to 4.
- Errors:
  - Input N header routing N → arb_err_o=1, packet delivered to L.
  - arb_credit_i at full credit → arb_err_o=1, count stays 4.
- ARB_HEADER_LEN_EN defined: header len=2 → exactly 2 transfers; len=0 → 1 transfer.
